// File: rtl/frame_rd_pkg.sv
// Shared types and defaults for the BRAM frame reader.
// The FSM state encoding and clog2 are used by the top level and its port widths.
package frame_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int H_ACTIVE_DEF = 128;
    localparam int V_ACTIVE_DEF = 64;
    localparam int ADDR_W_DEF   = 13;

    // Never returns 0 so that a 1-pixel dimension still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready register slice carrying {tuser, tlast, tdata}.
// An empty buffer forwards the incoming word in the same cycle, so it adds no latency.
module axis_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occ,
    output logic [1:0]   occ_nxt
);

    logic [W-1:0] buf_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         bypass;
    logic         push;
    logic         pop;

    // The upstream never offers a word when the buffer is full, so push needs no guard.
    always_comb begin
        bypass    = (occ == 2'd0) && in_valid && out_ready;
        push      = in_valid && !bypass;
        pop       = (occ != 2'd0) && out_ready;
        occ_nxt   = occ + {1'b0, push} - {1'b0, pop};
        out_valid = (occ != 2'd0) || in_valid;
        out_data  = '0;
        if (occ != 2'd0) begin
            out_data = buf_mem[rd_ptr];
        end else if (in_valid) begin
            out_data = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Reads a completed frame out of BRAM in raster order as an AXI4-Stream video stream.
// Define BLACKOUT_EN to add the rectangular blackout window ports and masking.
module bram_frame_reader
    import frame_rd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = 8,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int BLACK_VAL = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_done,
    output logic                        bram_en,
    output logic [ADDR_W-1:0]           bram_addr_out,
    input  logic [DATA_W-1:0]           bram_dout,
`ifdef BLACKOUT_EN
    input  logic [clog2(H_ACTIVE)-1:0]  blk_x0,
    input  logic [clog2(H_ACTIVE)-1:0]  blk_x1,
    input  logic [clog2(V_ACTIVE)-1:0]  blk_y0,
    input  logic [clog2(V_ACTIVE)-1:0]  blk_y1,
    input  logic                        blk_enable,
`endif
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        overrun
);

    localparam int XW = clog2(H_ACTIVE);
    localparam int YW = clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    function automatic logic [DATA_W-1:0] mask_pixel(input logic [DATA_W-1:0] pix, input logic hit);
        return hit ? DATA_W'(BLACK_VAL) : pix;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              pending;
    logic              start;
    logic              issue_last;
    logic              last_beat;
    logic              en_nxt;
    logic              blk_hit;
    logic              vld_p1;
    logic              tuser_p1;
    logic              tlast_p1;
    logic              blk_p1;
    logic [1:0]        skid_occ;
    logic [1:0]        skid_occ_nxt;
    logic [DATA_W+1:0] skid_in;
    logic [DATA_W+1:0] skid_out;

`ifdef BLACKOUT_EN
    logic [XW-1:0] blk_x0_r;
    logic [XW-1:0] blk_x1_r;
    logic [YW-1:0] blk_y0_r;
    logic [YW-1:0] blk_y1_r;
    logic          blk_en_r;

    assign blk_hit = blk_en_r && (x >= blk_x0_r) && (x <= blk_x1_r)
                              && (y >= blk_y0_r) && (y <= blk_y1_r);
`else
    assign blk_hit = 1'b0;
`endif

    // Once every read is issued, the beat that leaves with nothing else outstanding ends the frame.
    always_comb begin
        start      = (state == IDLE) && (frame_done || pending);
        issue_last = bram_en && (x == X_LAST) && (y == Y_LAST);
        last_beat  = (state == DRAIN) && m_axis_tvalid && m_axis_tready
                     && (({1'b0, skid_occ} + {2'b0, vld_p1}) == 3'd1);
        state_nxt  = state;
        case (state)
            IDLE:    if (start)      state_nxt = READ;
            READ:    if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (last_beat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Registered enable: next cycle's occupancy plus the read issued this cycle must leave room.
        en_nxt = (state_nxt == READ) && (({1'b0, skid_occ_nxt} + {2'b0, bram_en}) < 3'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bram_en       <= 1'b0;
            bram_addr_out <= '0;
            x             <= '0;
            y             <= '0;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
`ifdef BLACKOUT_EN
            blk_x0_r      <= '0;
            blk_x1_r      <= '0;
            blk_y0_r      <= '0;
            blk_y1_r      <= '0;
            blk_en_r      <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            bram_en <= en_nxt;

            if (start) begin
                pending <= pending && frame_done;
            end else if (frame_done && (state != IDLE)) begin
                pending <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef BLACKOUT_EN
                        blk_x0_r <= blk_x0;
                        blk_x1_r <= blk_x1;
                        blk_y0_r <= blk_y0;
                        blk_y1_r <= blk_y1;
                        blk_en_r <= blk_enable;
`endif
                    end
                end
                READ: begin
                    if (bram_en && !issue_last) begin
                        bram_addr_out <= bram_addr_out + ADDR_W'(1);
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        busy          <= 1'b0;
                        bram_addr_out <= '0;
                        x             <= '0;
                        y             <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: BRAM word in flight, tags captured when its address was issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bram_en;
        end
    end

    always_ff @(posedge clk) begin
        if (bram_en) begin
            tuser_p1 <= (x == '0) && (y == '0);
            tlast_p1 <= (x == X_LAST);
            blk_p1   <= blk_hit;
        end
    end

    assign skid_in = {tuser_p1, tlast_p1, mask_pixel(bram_dout, blk_p1)};

    axis_skid_buf #(.W(DATA_W + 2)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (vld_p1),
        .in_data   (skid_in),
        .out_valid (m_axis_tvalid),
        .out_data  (skid_out),
        .out_ready (m_axis_tready),
        .occ       (skid_occ),
        .occ_nxt   (skid_occ_nxt)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skid_out;

endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench for bram_frame_reader against a frame-level raster model.
// Exercises the blackout window as well when compiled with BLACKOUT_EN.
module tb_bram_frame_reader;

    localparam int H = 128;
    localparam int V = 64;
    localparam int N = H * V;
    localparam logic [7:0] BLACK = 8'd0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done = 1'b0;
    logic        bram_en;
    logic [12:0] bram_addr_out;
    logic [7:0]  bram_dout = 8'd0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        busy;
    logic        overrun;
`ifdef BLACKOUT_EN
    logic [6:0]  blk_x0 = '0;
    logic [6:0]  blk_x1 = '0;
    logic [5:0]  blk_y0 = '0;
    logic [5:0]  blk_y1 = '0;
    logic        blk_enable = 1'b0;
`endif

    bram_frame_reader dut (
        .clk           (clk),
        .reset         (reset),
        .frame_done    (frame_done),
        .bram_en       (bram_en),
        .bram_addr_out (bram_addr_out),
        .bram_dout     (bram_dout),
`ifdef BLACKOUT_EN
        .blk_x0        (blk_x0),
        .blk_x1        (blk_x1),
        .blk_y0        (blk_y0),
        .blk_y1        (blk_y1),
        .blk_enable    (blk_enable),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM: data appears the cycle after the enable.
    logic [7:0] mem [N];
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr_out];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_reads = 0;
    int n_beats = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    bit          stall_prev = 1'b0;
    logic [31:0] held = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_word();
        return {22'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata};
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    endtask

    // Expected frame in raster order: SOF on pixel 0, EOL on the last pixel of every line.
    task automatic push_frame(input int bx0, input int bx1, input int by0, input int by1, input bit ben);
        for (int i = 0; i < N; i++) begin
            int px;
            int py;
            logic [7:0] d;
            px = i % H;
            py = i / H;
            d  = mem[i];
            if (ben && px >= bx0 && px <= bx1 && py >= by0 && py <= by1) d = BLACK;
            exp_q.push_back({22'b0, (i == 0), (px == H - 1), d});
            addr_q.push_back(32'(i));
        end
    endtask

    // One clock: drive inputs on the falling edge, then score what the next rising edge will take.
    task automatic tick(input int mode, input logic fd);
        logic [31:0] e;
        @(negedge clk);
        frame_done = fd;
        case (mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (stall_prev) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_beat", beat_word(), held);
        end
        if (bram_en) begin
            n_reads++;
            if (addr_q.size() != 0) e = addr_q.pop_front();
            else e = 32'hdead_0000;
            check("read_addr", 32'(bram_addr_out), e);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 32'hdead_0000;
            check("beat", beat_word(), e);
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held = beat_word();
    endtask

    task automatic run_until_empty(input int mode, input int budget, output int cycles);
        cycles = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && cycles < budget) begin
            tick(mode, 1'b0);
            cycles++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int reads0;

        // Reset state
        #100;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        check("rst_addr", 32'(bram_addr_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_beat", beat_word(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1, 1'b0);
        check("idle_bram_en", 32'(bram_en), 32'd0);

        // Full frame, tready high: latency and 1 pixel/clock
        fill_mem();
        tick(1, 1'b1);
        push_frame(0, 0, 0, 0, 1'b0);
        tick(1, 1'b0);
        check("lat_bram_en", 32'(bram_en), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        tick(1, 1'b0);
        check("lat_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("lat_tuser", 32'(m_axis_tuser), 32'd1);
        run_until_empty(1, 20000, cyc);
        check("f1_cycles", 32'(cyc + 2), 32'(N + 1));
        check("f1_busy_at_last", 32'(busy), 32'd1);
        tick(1, 1'b0);
        check("f1_busy_after", 32'(busy), 32'd0);

        // Random backpressure
        fill_mem();
        tick(2, 1'b1);
        push_frame(0, 0, 0, 0, 1'b0);
        run_until_empty(2, 40000, cyc);
        tick(1, 1'b0);
        check("f2_busy_after", 32'(busy), 32'd0);
        check("f2_overrun", 32'(overrun), 32'd0);

        // Pending frame, then a lost frame
        fill_mem();
        tick(1, 1'b1);
        push_frame(0, 0, 0, 0, 1'b0);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin tick(1, 1'b0); cyc++; end
        tick(1, 1'b1);
        cyc++;
        push_frame(0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin tick(1, 1'b0); cyc++; end
        check("pend_overrun0", 32'(overrun), 32'd0);
        check("pend_busy", 32'(busy), 32'd1);
        tick(1, 1'b1);
        cyc++;
        tick(1, 1'b0);
        cyc++;
        check("ovr_set", 32'(overrun), 32'd1);
        begin
            int rest;
            run_until_empty(1, 40000, rest);
            cyc += rest;
        end
        check("b2b_cycles", 32'(cyc), 32'(2 * N + 3));
        tick(1, 1'b0);
        check("b2b_busy_after", 32'(busy), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame at beat 3000
        fill_mem();
        tick(1, 1'b1);
        push_frame(0, 0, 0, 0, 1'b0);
        n_beats = 0;
        cyc = 0;
        while (n_beats < 3000 && cyc < 10000) begin tick(1, 1'b0); cyc++; end
        check("mid_beats", 32'(n_beats), 32'd3000);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_bram_en", 32'(bram_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        addr_q.delete();
        stall_prev = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tick(1, 1'b0);

        // Restart after reset with tready held low for 50 cycles
        fill_mem();
        tick(0, 1'b1);
        push_frame(0, 0, 0, 0, 1'b0);
        reads0 = n_reads;
        for (int i = 0; i < 50; i++) tick(0, 1'b0);
        check("stall_reads_le2", 32'((n_reads - reads0) <= 2), 32'd1);
        check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("stall_tuser", 32'(m_axis_tuser), 32'd1);
        run_until_empty(1, 20000, cyc);
        tick(1, 1'b0);
        check("f4_busy_after", 32'(busy), 32'd0);

`ifdef BLACKOUT_EN
        // Blackout window x 10..20, y 5..6
        fill_mem();
        blk_x0 = 7'd10; blk_x1 = 7'd20; blk_y0 = 6'd5; blk_y1 = 6'd6; blk_enable = 1'b1;
        tick(1, 1'b1);
        push_frame(10, 20, 5, 6, 1'b1);
        blk_x0 = 7'd0; blk_x1 = 7'd127; blk_y0 = 6'd0; blk_y1 = 6'd63;
        run_until_empty(2, 40000, cyc);
        tick(1, 1'b0);
        // Empty window
        fill_mem();
        blk_x0 = 7'd30; blk_x1 = 7'd20; blk_y0 = 6'd5; blk_y1 = 6'd6;
        tick(1, 1'b1);
        push_frame(30, 20, 5, 6, 1'b1);
        run_until_empty(1, 20000, cyc);
        tick(1, 1'b0);
        blk_enable = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
